seq_det_param: RTL and testbench

//  Parametrised, runtime-programmable serial sequence detector. Next generation of the fixed-pattern Mealy detector.

---
 rtl/seq_det_param.sv | 116 +++++++++++
 tb/tb_seq_det_param.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_det_param
// Brief    : Runtime-programmable masked serial sequence detector (Mealy),
//            with overlap control and a saturating match counter.
// Revision : 1.0
// ============================================================================
module seq_det_param #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pattern,
  input  logic [N-1:0]     cfg_mask,
  input  logic             cfg_overlap,
  input  logic             in_valid,
  input  logic             data_in,
  output logic             data_out,
  output logic [CNT_W-1:0] match_cnt,
  input  logic             cnt_clr,
  output logic             busy
);

  localparam int               FILL_W    = (N <= 2) ? 1 : $clog2(N);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-2:0]     r_hist;
  logic [N-2:0]     w_hist_nxt;
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [N-1:0]     r_pattern;
  logic [N-1:0]     r_mask;
  logic             r_overlap;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     w_window;
  logic             w_hit;
  logic             w_match;

  // Oldest history bit lands in window[N-1], the live bit in window[0].
  assign w_window = {r_hist, data_in};
  assign w_hit    = (((w_window ^ r_pattern) & r_mask) == '0);
  assign w_match  = rst_n & in_valid & ~cfg_load & (r_state == ST_RUN) & w_hit;

  assign data_out  = w_match;
  assign busy      = (r_state == ST_RUN);
  assign match_cnt = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
      r_hist  <= '0;
      r_fill  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    if (cfg_load || (w_match && !r_overlap)) begin
      // Flush: the next match must be built from N fresh accepted bits.
      w_state_nxt = ST_FILL;
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
    end else if (in_valid) begin
      w_hist_nxt = w_window[N-2:0];
      if (r_state == ST_FILL) begin
        w_fill_nxt = r_fill + FILL_ONE;
        if ((r_fill + FILL_ONE) == FILL_LAST) begin
          w_state_nxt = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern <= '0;
      r_mask    <= '1;
      r_overlap <= 1'b1;
    end else if (cfg_load) begin
      r_pattern <= cfg_pattern;
      r_mask    <= cfg_mask;
      r_overlap <= cfg_overlap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_det_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_param
// Brief    : Directed and randomized bench for seq_det_param against a
//            queue-based reference of the accepted bit stream.
// Revision : 1.0
// ============================================================================
module tb_seq_det_param;

  localparam int N       = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_load;
  logic [N-1:0]     cfg_pattern;
  logic [N-1:0]     cfg_mask;
  logic             cfg_overlap;
  logic             in_valid;
  logic             data_in;
  logic             data_out;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_clr;
  logic             busy;

  always #5 clk = ~clk;

  seq_det_param #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_mask   (cfg_mask),
    .cfg_overlap(cfg_overlap),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .data_out   (data_out),
    .match_cnt  (match_cnt),
    .cnt_clr    (cnt_clr),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: the accepted bits since the last flush, newest at the back.
  bit           q[$];
  logic [N-1:0] m_pat;
  logic [N-1:0] m_mask;
  bit           m_ovl;
  int           m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt  = 0;
    m_pat  = '0;
    m_mask = '1;
    m_ovl  = 1'b1;
  endtask

  function automatic bit model_hit(input bit d);
    bit seq[$];
    if (q.size() < N - 1) return 1'b0;
    seq = q;
    seq.push_back(d);
    // seq[N-1] is the newest bit, compared against pattern bit 0.
    for (int i = 0; i < N; i++) begin
      if (m_mask[i] && (seq[N-1-i] != m_pat[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input bit v, input bit d, input bit ld, input bit clr, output bit seen);
    bit exp_out;
    @(negedge clk);
    in_valid = v;
    data_in  = d;
    cfg_load = ld;
    cnt_clr  = clr;
    #1;
    exp_out = v && !ld && model_hit(d);
    check("data_out", data_out, exp_out);
    seen = data_out;
    @(posedge clk);
    if (ld) begin
      m_pat  = cfg_pattern;
      m_mask = cfg_mask;
      m_ovl  = cfg_overlap;
      q.delete();
    end else if (v) begin
      if (exp_out && !m_ovl) begin
        q.delete();
      end else begin
        q.push_back(d);
        if (q.size() > N - 1) void'(q.pop_front());
      end
    end
    if (clr) m_cnt = 0;
    else if (exp_out && m_cnt < CNT_MAX) m_cnt++;
    #1;
    check("busy", busy, (q.size() >= N - 1));
    check("match_cnt", match_cnt, m_cnt);
  endtask

  task automatic load_cfg(input logic [N-1:0] pat, input logic [N-1:0] msk, input bit ovl);
    bit s;
    cfg_pattern = pat;
    cfg_mask    = msk;
    cfg_overlap = ovl;
    step(1'b0, 1'b0, 1'b1, 1'b0, s);
  endtask

  task automatic clear_cnt();
    bit s;
    step(1'b0, 1'b0, 1'b0, 1'b1, s);
  endtask

  // pulses[k] records data_out on the k-th bit sent (bit 0 sent first).
  task automatic send_bits(input logic [31:0] bits, input int len, output logic [31:0] pulses);
    bit s;
    pulses = '0;
    for (int k = 0; k < len; k++) begin
      step(1'b1, bits[len-1-k], 1'b0, 1'b0, s);
      pulses[k] = s;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    data_in  = 1'($urandom_range(0, 1));
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
    model_reset();
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", match_cnt, 0);
    @(posedge clk);
    #1;
    check("rst_hold_data_out", data_out, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] pulses;
    bit          s;
    rst_n = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_mask = '1; cfg_overlap = 1'b1;
    in_valid = 1'b0; data_in = 1'b0; cnt_clr = 1'b0;
    model_reset();
    #12;
    check("reset_busy", busy, 0);
    check("reset_cnt", match_cnt, 0);
    check("reset_data_out", data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default config after reset: pattern 0000, full mask -> runs of zeros match.
    send_bits(32'b00000, 5, pulses);
    check("default_pulses", pulses, 32'h18);

    // Overlapping 0110 over 0110110.
    load_cfg(4'b0110, 4'b1111, 1'b1);
    clear_cnt();
    send_bits(32'b0110110, 7, pulses);
    check("t1_pulses", pulses, 32'h48);
    check("t1_cnt", match_cnt, 2);

    // Same stream, non-overlapping.
    load_cfg(4'b0110, 4'b1111, 1'b0);
    clear_cnt();
    send_bits(32'b0110110, 7, pulses);
    check("t2_pulses", pulses, 32'h08);
    check("t2_cnt", match_cnt, 1);

    // 1010 with idle gaps between bits.
    load_cfg(4'b1010, 4'b1111, 1'b1);
    clear_cnt();
    pulses = '0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, (k % 2) == 0, 1'b0, 1'b0, s);
      pulses[k] = s;
      for (int g = 0; g < 2; g++) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, s);
        check("t3_gap", s, 0);
      end
    end
    check("t3_pulses", pulses, 32'h08);
    check("t3_cnt", match_cnt, 1);

    // Masked pattern 1xx1.
    load_cfg(4'b1001, 4'b1001, 1'b1);
    send_bits(32'b1011, 4, pulses);
    check("t4_hit", pulses, 32'h08);
    load_cfg(4'b1001, 4'b1001, 1'b1);
    send_bits(32'b0111, 4, pulses);
    check("t4_miss", pulses, 32'h00);

    // All-zero mask: every accepted bit in RUN matches; counter saturates.
    load_cfg(4'b0000, 4'b0000, 1'b1);
    clear_cnt();
    send_bits(32'($urandom_range(0, 255)), 8, pulses);
    check("t5_pulses", pulses, 32'hF8);
    check("t5_sat", match_cnt, 3);
    step(1'b1, 1'b1, 1'b0, 1'b1, s);
    check("t5_clr_hit", s, 1);
    check("t5_clr", match_cnt, 0);

    // Reset mid-stream, then rebuild history from scratch.
    load_cfg(4'b0110, 4'b1111, 1'b1);
    send_bits(32'b01, 2, pulses);
    apply_reset();
    load_cfg(4'b0110, 4'b1111, 1'b1);
    send_bits(32'b10, 2, pulses);
    check("t6_no_match", pulses, 32'h0);
    check("t6_busy_low", busy, 0);
    send_bits(32'b0, 1, pulses);
    check("t6_busy_high", busy, 1);
    send_bits(32'b110, 3, pulses);
    check("t6_pulses", pulses, 32'h4);

    // Random traffic against the reference.
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        cfg_pattern = N'($urandom);
        cfg_mask    = N'($urandom | $urandom);
        cfg_overlap = 1'($urandom_range(0, 1));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, s);
      end else if (r < 4) begin
        apply_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'b0,
             $urandom_range(0, 40) == 0, s);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
